// File: rtl/lp805x_ntimer_sched_pkg.sv
// Shared definitions for the lp805x timer scheduler: SFR map, FSM
// encodings and the write-one-to-clear merge helper.
package lp805x_ntimer_sched_pkg;

    // Default SFR base and register offsets (SCHCTL=EC, SCHFLG=ED, SCHSEL=EE, SCHRLD=EF)
    localparam logic [7:0] SCH_BASE_DEF = 8'hEC;
    localparam logic [7:0] SCHCTL_OFS   = 8'h00;
    localparam logic [7:0] SCHFLG_OFS   = 8'h01;
    localparam logic [7:0] SCHSEL_OFS   = 8'h02;
    localparam logic [7:0] SCHRLD_OFS   = 8'h03;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } sched_state_e;

    // Hardware set wins over a simultaneous software clear.
    function automatic logic [4:0] w1c_merge(
        input logic [4:0] cur,
        input logic [4:0] hw_set,
        input logic [4:0] sw_clr
    );
        return hw_set | (cur & ~sw_clr);
    endfunction

endpackage

// File: rtl/lp805x_ntimer_sched_chan.sv
// One virtual timer channel: count/reload registers and the
// decrement, reload and expiry detection for a single scan slot.
module lp805x_ntimer_sched_chan (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan,
    input  logic       per,
    input  logic       ld,
    input  logic [7:0] ld_data,
    output logic [7:0] cnt,
    output logic       expire
);

    logic [7:0] cnt_r;
    logic [7:0] rld_r;
    logic       dec_s;

    // A software reload in the same cycle suppresses the decrement entirely.
    assign dec_s  = scan && !ld && (cnt_r != 8'd0);
    assign expire = dec_s && (cnt_r == 8'd1);
    assign cnt    = cnt_r;

    // Count/reload registers: load beats decrement; expiry reloads or parks at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
            rld_r <= 8'd0;
        end else if (ld) begin
            cnt_r <= ld_data;
            rld_r <= ld_data;
        end else if (dec_s) begin
            if (cnt_r == 8'd1) begin
                cnt_r <= per ? rld_r : 8'd0;
            end else begin
                cnt_r <= cnt_r - 8'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/lp805x_ntimer_sched.sv
// Virtual timer scheduler: multiplexes four down-counting channels onto
// the new timer overflow tick, one channel per cycle, with SFR access.
module lp805x_ntimer_sched
    import lp805x_ntimer_sched_pkg::*;
#(
    parameter int         NCH      = 4,
    parameter logic [7:0] SCH_BASE = SCH_BASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] data_in,
    input  logic [7:0] rd_addr,
    output logic [7:0] data_out,
    output logic [3:0] ch_evt,
    output logic       int_o
);

    localparam logic [7:0] CTL_A = SCH_BASE + SCHCTL_OFS;
    localparam logic [7:0] FLG_A = SCH_BASE + SCHFLG_OFS;
    localparam logic [7:0] SEL_A = SCH_BASE + SCHSEL_OFS;
    localparam logic [7:0] RLD_A = SCH_BASE + SCHRLD_OFS;

    sched_state_e state_r, state_nxt_s;
    logic [1:0]   idx_r, idx_nxt_s, pend_r, pend_nxt_s, sel_r;
    logic         gen_r, ovr_r, ovr_set_s, rd_en_r, rd_en_s;
    logic [3:0]   cen_r, per_r, flg_r, ch_evt_r;
    logic [3:0]   scan_s, ld_s, expire_s, cen_nxt_s;
    logic [4:0]   flg_nxt_s;
    logic [7:0]   rd_data_r, rd_data_s;
    logic [7:0]   cnt_s [4];
    logic [2:0]   pend_sum_s;
    logic         wr_ctl_s, wr_flg_s, wr_sel_s, wr_rld_s;

    assign wr_ctl_s = wr && (wr_addr == CTL_A);
    assign wr_flg_s = wr && (wr_addr == FLG_A);
    assign wr_sel_s = wr && (wr_addr == SEL_A);
    assign wr_rld_s = wr && (wr_addr == RLD_A);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign scan_s[g] = gen_r && (state_r == ST_SCAN) && (idx_r == 2'(g)) && cen_r[g];
        assign ld_s[g]   = wr_rld_s && (sel_r == 2'(g));
        lp805x_ntimer_sched_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .scan    (scan_s[g]),
            .per     (per_r[g]),
            .ld      (ld_s[g]),
            .ld_data (data_in),
            .cnt     (cnt_s[g]),
            .expire  (expire_s[g])
        );
    end

    // Next state, scan index and pending-tick bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        pend_nxt_s  = pend_r;
        ovr_set_s   = 1'b0;
        pend_sum_s  = {1'b0, pend_r} + {2'b00, tick_in && (state_r == ST_SCAN)};
        if (!gen_r) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 2'd0;
            pend_nxt_s  = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_nxt_s = 2'd0;
                    if (tick_in) begin
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (idx_r == 2'd3) begin
                        // The restart frees a slot, so a tick here is never lost.
                        idx_nxt_s = 2'd0;
                        if (pend_sum_s == 3'd0) begin
                            state_nxt_s = ST_IDLE;
                            pend_nxt_s  = 2'd0;
                        end else begin
                            state_nxt_s = ST_SCAN;
                            pend_nxt_s  = 2'(pend_sum_s - 3'd1);
                        end
                    end else begin
                        idx_nxt_s = idx_r + 2'd1;
                        if (pend_sum_s > 3'd3) begin
                            ovr_set_s  = 1'b1;
                            pend_nxt_s = 2'd3;
                        end else begin
                            pend_nxt_s = pend_sum_s[1:0];
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = 2'd0;
                    pend_nxt_s  = 2'd0;
                end
            endcase
        end
    end

    // FSM, scan index and pending counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            pend_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    // Software writes to CEN take priority over a one-shot self-disable.
    assign cen_nxt_s = wr_ctl_s ? data_in[3:0] : (cen_r & ~(expire_s & ~per_r));
    assign flg_nxt_s = w1c_merge({ovr_r, flg_r}, {ovr_set_s, expire_s},
                                 wr_flg_s ? {data_in[7], data_in[3:0]} : 5'b00000);

    // Control, select, flag registers and the registered event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_r    <= 1'b0;
            cen_r    <= 4'd0;
            per_r    <= 4'd0;
            sel_r    <= 2'd0;
            flg_r    <= 4'd0;
            ovr_r    <= 1'b0;
            ch_evt_r <= 4'd0;
        end else begin
            gen_r    <= wr_ctl_s ? data_in[7] : gen_r;
            cen_r    <= cen_nxt_s;
            per_r    <= wr_sel_s ? data_in[7:4] : per_r;
            sel_r    <= wr_sel_s ? data_in[1:0] : sel_r;
            flg_r    <= flg_nxt_s[3:0];
            ovr_r    <= flg_nxt_s[4];
            ch_evt_r <= expire_s;
        end
    end

    // Read mux for the addressed SFR; unmapped addresses release the bus.
    always_comb begin
        rd_en_s   = 1'b1;
        rd_data_s = 8'h00;
        case (rd_addr)
            CTL_A:   rd_data_s = {gen_r, 3'b000, cen_r};
            FLG_A:   rd_data_s = {ovr_r, 3'b000, flg_r};
            SEL_A:   rd_data_s = {per_r, 2'b00, sel_r};
            RLD_A:   rd_data_s = cnt_s[sel_r];
            default: begin
                rd_en_s   = 1'b0;
                rd_data_s = 8'h00;
            end
        endcase
    end

    // Registered read data and bus-drive enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_r   <= 1'b0;
            rd_data_r <= 8'h00;
        end else begin
            rd_en_r   <= rd_en_s;
            rd_data_r <= rd_data_s;
        end
    end

    assign data_out = rd_en_r ? rd_data_r : 8'hzz;
    assign ch_evt   = ch_evt_r;
    assign int_o    = gen_r & ((|flg_r) | ovr_r);

endmodule
